// File: rtl/updown_counter_pkg.sv
// Shared definitions for the parametrised up/down counter: direction
// encoding, boundary-mode enum and the load clamp used by RTL and bench.
package updown_counter_pkg;

    // Direction encoding on the sel input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Behaviour at the 0 / MAX_VAL boundaries.
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Limit a parallel-load value to the counter range 0..max.
    function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap or saturate at a configurable
// terminal count, enable, synchronous clear, clamped parallel load, and
// boundary flags (combinational at_max/at_min, registered bnd_evt/ovf_sticky).
//
// Handshake: there is none; every control input is sampled at each rising
// edge and acted on with priority rst > clr > load > en.
module updown_counter_param
    import updown_counter_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] MAX_VAL   = 32'((64'd1 << WIDTH) - 64'd1),
    parameter logic [31:0] RESET_VAL = 32'd0,
    parameter int          SATURATE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sel,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             at_max,
    output logic             at_min,
    output logic             bnd_evt,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] MAX_W   = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_W = RESET_VAL[WIDTH-1:0];
    localparam mode_e            BND_MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             evt_q, evt_d;
    logic             sticky_q, sticky_d;

    // The clamp works in 32 bits; its result never exceeds MAX_VAL, so the
    // bits above WIDTH are always zero and only the low slice is used.
    logic [31:0] load_clamped;
    logic        unused_load_bits;

    assign load_clamped     = clamp_load(32'(load_val), MAX_VAL);
    assign unused_load_bits = ^load_clamped;

    // Next-state decode: clr > load > en; boundary compares use MAX_VAL.
    always_comb begin
        cnt_d    = cnt_q;
        evt_d    = 1'b0;
        sticky_d = sticky_q;
        if (clr) begin
            cnt_d    = RESET_W;
            sticky_d = 1'b0;
        end else if (load) begin
            cnt_d    = load_clamped[WIDTH-1:0];
            sticky_d = 1'b0;
        end else if (en) begin
            if (sel == DIR_UP) begin
                if (cnt_q == MAX_W) begin
                    evt_d    = 1'b1;
                    sticky_d = 1'b1;
                    cnt_d    = (BND_MODE == MODE_SAT) ? MAX_W : '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    evt_d    = 1'b1;
                    sticky_d = 1'b1;
                    cnt_d    = (BND_MODE == MODE_SAT) ? '0 : MAX_W;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= RESET_W;
            evt_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            evt_q    <= evt_d;
            sticky_q <= sticky_d;
        end
    end

    assign out        = cnt_q;
    assign at_max     = (cnt_q == MAX_W);
    assign at_min     = (cnt_q == '0);
    assign bnd_evt    = evt_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: three instances share stimulus
// (4-bit wrap, 4-bit saturate, decade wrap); each task checks the relevant one.
module tb_updown_counter_param;
    import updown_counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0, en = 1'b0, sel = 1'b0, clr = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] out_w, out_s, out_d;
    logic       amax_w, amin_w, evt_w, stk_w;
    logic       amax_s, amin_s, evt_s, stk_s;
    logic       amax_d, amin_d, evt_d, stk_d;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .MAX_VAL(32'd15), .RESET_VAL(32'd0), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .clr(clr), .load(load), .load_val(load_val),
        .out(out_w), .at_max(amax_w), .at_min(amin_w), .bnd_evt(evt_w), .ovf_sticky(stk_w));

    updown_counter_param #(.WIDTH(4), .MAX_VAL(32'd15), .RESET_VAL(32'd0), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .clr(clr), .load(load), .load_val(load_val),
        .out(out_s), .at_max(amax_s), .at_min(amin_s), .bnd_evt(evt_s), .ovf_sticky(stk_s));

    updown_counter_param #(.WIDTH(4), .MAX_VAL(32'd9), .RESET_VAL(32'd0), .SATURATE(0)) u_dec (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .clr(clr), .load(load), .load_val(load_val),
        .out(out_d), .at_max(amax_d), .at_min(amin_d), .bnd_evt(evt_d), .ovf_sticky(stk_d));

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (out_w !== 4'd0) begin n_fail++; $display("FAIL reset_out_w: got %0d want 0", out_w); end
        n_checks++; if (amin_w !== 1'b1) begin n_fail++; $display("FAIL reset_at_min_w: got %b want 1", amin_w); end
        n_checks++; if (evt_w !== 1'b0) begin n_fail++; $display("FAIL reset_bnd_evt_w: got %b want 0", evt_w); end
        n_checks++; if (stk_w !== 1'b0) begin n_fail++; $display("FAIL reset_sticky_w: got %b want 0", stk_w); end
        n_checks++; if (out_s !== 4'd0) begin n_fail++; $display("FAIL reset_out_s: got %0d want 0", out_s); end
        n_checks++; if (out_d !== 4'd0) begin n_fail++; $display("FAIL reset_out_d: got %0d want 0", out_d); end
    endtask

    task automatic test_up_wrap();
        logic [3:0] e_out;
        logic       e_evt, e_stk;
        en = 1'b1; sel = DIR_UP;
        for (int i = 1; i <= 17; i++) begin
            tick();
            e_out = 4'(i % 16);
            e_evt = (i == 16);
            e_stk = (i >= 16);
            n_checks++; if (out_w !== e_out) begin n_fail++; $display("FAIL up_wrap_out[%0d]: got %0d want %0d", i, out_w, e_out); end
            n_checks++; if (evt_w !== e_evt) begin n_fail++; $display("FAIL up_wrap_evt[%0d]: got %b want %b", i, evt_w, e_evt); end
            n_checks++; if (stk_w !== e_stk) begin n_fail++; $display("FAIL up_wrap_sticky[%0d]: got %b want %b", i, stk_w, e_stk); end
            n_checks++; if (amax_w !== (i == 15)) begin n_fail++; $display("FAIL up_wrap_at_max[%0d]: got %b want %b", i, amax_w, (i == 15)); end
        end
        en = 1'b0;
    endtask

    task automatic test_down_sat();
        logic [3:0] e_out [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
        logic       e_evt [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       e_min [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        load = 1'b1; load_val = 4'd2;
        tick();
        load = 1'b0;
        n_checks++; if (out_s !== 4'd2) begin n_fail++; $display("FAIL sat_load_out: got %0d want 2", out_s); end
        n_checks++; if (stk_s !== 1'b0) begin n_fail++; $display("FAIL sat_load_sticky: got %b want 0", stk_s); end
        en = 1'b1; sel = DIR_DOWN;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (out_s !== e_out[i]) begin n_fail++; $display("FAIL sat_down_out[%0d]: got %0d want %0d", i, out_s, e_out[i]); end
            n_checks++; if (evt_s !== e_evt[i]) begin n_fail++; $display("FAIL sat_down_evt[%0d]: got %b want %b", i, evt_s, e_evt[i]); end
            n_checks++; if (amin_s !== e_min[i]) begin n_fail++; $display("FAIL sat_down_at_min[%0d]: got %b want %b", i, amin_s, e_min[i]); end
        end
        n_checks++; if (stk_s !== 1'b1) begin n_fail++; $display("FAIL sat_down_sticky: got %b want 1", stk_s); end
        en = 1'b0;
    endtask

    task automatic test_decade();
        logic [31:0] e_clamp;
        load = 1'b1; load_val = 4'd8;
        tick();
        load = 1'b0;
        n_checks++; if (out_d !== 4'd8) begin n_fail++; $display("FAIL dec_load8: got %0d want 8", out_d); end
        en = 1'b1; sel = DIR_UP;
        tick();
        n_checks++; if (out_d !== 4'd9) begin n_fail++; $display("FAIL dec_up9: got %0d want 9", out_d); end
        n_checks++; if (amax_d !== 1'b1) begin n_fail++; $display("FAIL dec_at_max9: got %b want 1", amax_d); end
        n_checks++; if (evt_d !== 1'b0) begin n_fail++; $display("FAIL dec_evt9: got %b want 0", evt_d); end
        tick();
        n_checks++; if (out_d !== 4'd0) begin n_fail++; $display("FAIL dec_wrap0: got %0d want 0", out_d); end
        n_checks++; if (evt_d !== 1'b1) begin n_fail++; $display("FAIL dec_wrap_evt: got %b want 1", evt_d); end
        n_checks++; if (stk_d !== 1'b1) begin n_fail++; $display("FAIL dec_wrap_sticky: got %b want 1", stk_d); end
        en = 1'b0; load = 1'b1; load_val = 4'd12;
        e_clamp = clamp_load(32'd12, 32'd9);
        tick();
        load = 1'b0;
        n_checks++; if (out_d !== e_clamp[3:0]) begin n_fail++; $display("FAIL dec_clamp: got %0d want %0d", out_d, e_clamp[3:0]); end
        n_checks++; if (amax_d !== 1'b1) begin n_fail++; $display("FAIL dec_clamp_at_max: got %b want 1", amax_d); end
        n_checks++; if (stk_d !== 1'b0) begin n_fail++; $display("FAIL dec_clamp_sticky: got %b want 0", stk_d); end
        n_checks++; if (evt_d !== 1'b0) begin n_fail++; $display("FAIL dec_clamp_evt: got %b want 0", evt_d); end
        // Loading 12 into the 0..15 counter is not clamped.
        n_checks++; if (out_w !== 4'd12) begin n_fail++; $display("FAIL wrap_noclamp: got %0d want 12", out_w); end
    endtask

    task automatic test_priority();
        rst = 1'b1; clr = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1; sel = DIR_UP;
        tick();
        n_checks++; if (out_w !== 4'd0) begin n_fail++; $display("FAIL prio_rst: got %0d want 0", out_w); end
        n_checks++; if (stk_w !== 1'b0) begin n_fail++; $display("FAIL prio_rst_sticky: got %b want 0", stk_w); end
        rst = 1'b0;
        tick();
        n_checks++; if (out_w !== 4'd0) begin n_fail++; $display("FAIL prio_clr: got %0d want 0", out_w); end
        clr = 1'b0;
        tick();
        n_checks++; if (out_w !== 4'd5) begin n_fail++; $display("FAIL prio_load: got %0d want 5", out_w); end
        load = 1'b0;
    endtask

    task automatic test_mid_reset();
        en = 1'b1; sel = DIR_UP;
        tick();
        n_checks++; if (out_w !== 4'd6) begin n_fail++; $display("FAIL mid_up6: got %0d want 6", out_w); end
        tick();
        n_checks++; if (out_w !== 4'd7) begin n_fail++; $display("FAIL mid_up7: got %0d want 7", out_w); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (out_w !== 4'd0) begin n_fail++; $display("FAIL mid_rst_out: got %0d want 0", out_w); end
        n_checks++; if (evt_w !== 1'b0) begin n_fail++; $display("FAIL mid_rst_evt: got %b want 0", evt_w); end
        tick();
        n_checks++; if (out_w !== 4'd1) begin n_fail++; $display("FAIL mid_after_rst: got %0d want 1", out_w); end
        n_checks++; if (evt_w !== 1'b0) begin n_fail++; $display("FAIL mid_after_evt: got %b want 0", evt_w); end
    endtask

    task automatic test_back_to_back();
        // Direction flips every edge with no dead cycle, then wraps downward.
        sel = DIR_DOWN;
        tick();
        n_checks++; if (out_w !== 4'd0) begin n_fail++; $display("FAIL b2b_down0: got %0d want 0", out_w); end
        sel = DIR_UP;
        tick();
        n_checks++; if (out_w !== 4'd1) begin n_fail++; $display("FAIL b2b_up1: got %0d want 1", out_w); end
        sel = DIR_DOWN;
        tick();
        n_checks++; if (out_w !== 4'd0) begin n_fail++; $display("FAIL b2b_down0b: got %0d want 0", out_w); end
        tick();
        n_checks++; if (out_w !== 4'd15) begin n_fail++; $display("FAIL b2b_wrap15: got %0d want 15", out_w); end
        n_checks++; if (evt_w !== 1'b1) begin n_fail++; $display("FAIL b2b_wrap_evt: got %b want 1", evt_w); end
        n_checks++; if (stk_w !== 1'b1) begin n_fail++; $display("FAIL b2b_wrap_sticky: got %b want 1", stk_w); end
        // clr at the top boundary with en up must not raise an event.
        clr = 1'b1; sel = DIR_UP;
        tick();
        clr = 1'b0; en = 1'b0;
        n_checks++; if (out_w !== 4'd0) begin n_fail++; $display("FAIL bnd_clr_out: got %0d want 0", out_w); end
        n_checks++; if (evt_w !== 1'b0) begin n_fail++; $display("FAIL bnd_clr_evt: got %b want 0", evt_w); end
        n_checks++; if (stk_w !== 1'b0) begin n_fail++; $display("FAIL bnd_clr_sticky: got %b want 0", stk_w); end
        // Hold with en low.
        tick();
        n_checks++; if (out_w !== 4'd0) begin n_fail++; $display("FAIL hold_out: got %0d want 0", out_w); end
        n_checks++; if (evt_w !== 1'b0) begin n_fail++; $display("FAIL hold_evt: got %b want 0", evt_w); end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_decade();
        test_priority();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised successor to the 4-bit up/down counter. Adds configurable width and modulus, a selectable wrap or saturate mode, enable, synchronous clear, parallel load and boundary flags. It is used as a generic event/position counter in datapath and test infrastructure, and drives status logic through registered flags.

Parameters:
WIDTH, 8, counter width in bits (legal range 2..32)
MAX_VAL, 2**WIDTH-1, terminal count; the counter range is 0..MAX_VAL (must be >= 1 and <= 2**WIDTH-1)
RESET_VAL, 0, value of out after rst or clr (must be <= MAX_VAL)
SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  reset, synchronous and active-high
en  input  1  count enable
sel  input  1  direction: 1 = up, 0 = down
clr  input  1  synchronous clear to RESET_VAL
load  input  1  parallel load strobe
load_val  input  WIDTH  value to load
out  output  WIDTH  current count, registered
at_max  output  1  combinational decode: out == MAX_VAL
at_min  output  1  combinational decode: out == 0
bnd_evt  output  1  registered one-cycle pulse on a boundary crossing or a boundary hit
ovf_sticky  output  1  registered sticky flag: at least one boundary event since the last rst, clr or load

Behaviour:
- Reset (rst = 1 at the clock edge): out = RESET_VAL, bnd_evt = 0, ovf_sticky = 0. No asynchronous path.
- Priority per edge: rst > clr > load > en. Inputs with lower priority are ignored in that cycle.
- clr: out = RESET_VAL, bnd_evt = 0, ovf_sticky = 0.
- load: out = load_val, or out = MAX_VAL if load_val > MAX_VAL (clamp). bnd_evt = 0, ovf_sticky = 0. The loaded value is visible on out in the next cycle.
- en = 0 with no clr or load: out holds and bnd_evt = 0.
- en = 1, sel = 1:
  - If out < MAX_VAL: out + 1.
  - If out == MAX_VAL: with SATURATE = 0, out wraps to 0; with SATURATE = 1, out holds at MAX_VAL. In both cases bnd_evt = 1 and ovf_sticky = 1.
- en = 1, sel = 0:
  - If out > 0: out - 1.
  - If out == 0: with SATURATE = 0, out wraps to MAX_VAL; with SATURATE = 1, out holds at 0. In both cases bnd_evt = 1 and ovf_sticky = 1.
- Latency: one cycle from the input sampled at an edge to the updated out, bnd_evt and ovf_sticky. at_max and at_min follow out combinationally.
- bnd_evt is high for exactly one cycle per event. Back-to-back saturated attempts produce a pulse every cycle.
- Arithmetic is done in WIDTH bits. The wrap compare uses MAX_VAL, not the natural WIDTH-bit overflow, so a non-power-of-two modulus works (for example MAX_VAL = 9 gives a decade counter).
- A direction change mid-count takes effect on the next edge, with no dead cycle.
- Reset, clr or load asserted while the counter is sitting at a boundary suppresses that cycle's bnd_evt.

Decomposition:
- Shared package updown_counter_pkg holds:
  - the direction encoding constants DIR_UP = 1'b1 and DIR_DOWN = 1'b0;
  - an enum for the boundary mode, MODE_WRAP and MODE_SAT, mapped to SATURATE;
  - a function clamp_load(val, max) used by both the RTL and the bench model.
- No sub-module is needed. The optional next-state function bnd_next (combinational, returns next count and the event bit) may be split out for reuse in a multi-channel bank later.

Test Plan:
- Reset: WIDTH = 4, MAX_VAL = 15, RESET_VAL = 0; rst = 1 for 2 cycles -> out = 0, at_min = 1, bnd_evt = 0, ovf_sticky = 0.
- Up-count wrap: SATURATE = 0, en = 1, sel = 1 for 17 cycles from 0 -> out runs 1..15, 0, 1; bnd_evt is high only in the cycle out becomes 0; ovf_sticky = 1 from that point.
- Down-count saturate: SATURATE = 1, load load_val = 2, then en = 1, sel = 0 for 4 cycles -> out = 1, 0, 0, 0; bnd_evt = 0, 0, 1, 1; at_min = 1 from the second cycle.
- Decade counter: MAX_VAL = 9, count up from 8 -> out = 9, 0; load load_val = 12 -> out = 9 (clamped), at_max = 1, ovf_sticky cleared.
- Priority: assert rst, clr, load (load_val = 5) and en together -> out = RESET_VAL. Then clr with load (load_val = 5) -> out = RESET_VAL. Then load with en, sel = 1 -> out = 5, not 6.
- Mid-operation reset: count up to 7, assert rst for 1 cycle with en held at 1 -> out = RESET_VAL the next cycle, then RESET_VAL + 1, with no bnd_evt.
